// File: rtl/gate_tt_checker_pkg.sv
// Shared definitions for the gate truth-table checker.
//   state_e      : checker FSM states
//   EXP_ROWn     : expected y_in vector for row n (row index = {A,B})
//   Y_*          : bit positions of each gate result within y_in
//   CNT_W        : dwell counter width (covers DWELL_CYCLES up to 255)
//   exp_row()    : expected y_in lookup by row index
package gate_tt_checker_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_e;

   // y_in bit order: {NOT A, XOR, NOR, OR, NAND, AND}
   localparam logic [5:0] EXP_ROW0 = 6'b101010;  // A=0 B=0
   localparam logic [5:0] EXP_ROW1 = 6'b110110;  // A=0 B=1
   localparam logic [5:0] EXP_ROW2 = 6'b010110;  // A=1 B=0
   localparam logic [5:0] EXP_ROW3 = 6'b000101;  // A=1 B=1

   localparam int unsigned Y_AND  = 0;
   localparam int unsigned Y_NAND = 1;
   localparam int unsigned Y_OR   = 2;
   localparam int unsigned Y_NOR  = 3;
   localparam int unsigned Y_XOR  = 4;
   localparam int unsigned Y_NOTA = 5;

   localparam int unsigned CNT_W = 8;

   function automatic logic [5:0] exp_row(input logic [1:0] r);
      logic [5:0] v;
      case (r)
         2'd0:    v = EXP_ROW0;
         2'd1:    v = EXP_ROW1;
         2'd2:    v = EXP_ROW2;
         default: v = EXP_ROW3;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/gate_tt_dwell_cnt.sv
// Loadable down-counter with zero flag, used to time the DRIVE dwell.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i (has priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : counter currently holds zero
module gate_tt_dwell_cnt
   import gate_tt_checker_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table sweep checker for a six-gate stage (AND, NAND, OR, NOR, XOR, NOT A).
// Steps A/B through rows 0..3, holds each row DWELL_CYCLES cycles, samples y_in,
// and reports per-row mismatches plus the first mismatching y_in snapshot.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle sweep request (ignored while a sweep runs)
//   loop_en    : restart automatically after each sweep
//   y_in       : gate results {NOT A, XOR, NOR, OR, NAND, AND}
//   a_out/b_out: gate stimulus (row index bits 1/0)
//   busy       : sweep in progress
//   done       : one-cycle end-of-sweep pulse
//   pass       : last completed sweep had no mismatches
//   err_mask   : per-row mismatch flags of the last sweep
//   err_y      : y_in snapshot of the first mismatching row
module gate_tt_checker
   import gate_tt_checker_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       loop_en,
   input  logic [5:0] y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask,
   output logic [5:0] err_y
);

   // Counter is loaded with DWELL_CYCLES-1 and DRIVE exits when it reads zero,
   // giving exactly DWELL_CYCLES cycles in DRIVE.
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] r_q, r_d;
   logic [3:0] err_mask_q, err_mask_d;
   logic [5:0] err_y_q, err_y_d;
   logic       a_q, a_d, b_q, b_d;
   logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;

   logic       cnt_load, cnt_dec, cnt_zero;
   logic       sweep_init;

   gate_tt_dwell_cnt u_dwell (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (cnt_load),
      .load_val_i(DWELL_LOAD),
      .dec_i     (cnt_dec),
      .zero_o    (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      err_mask_d = err_mask_q;
      err_y_d    = err_y_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      sweep_init = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) sweep_init = 1'b1;
         end
         S_DRIVE: begin
            cnt_dec = 1'b1;
            if (cnt_zero) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (y_in != exp_row(r_q)) begin
               err_mask_d[r_q] = 1'b1;
               // An all-clear mask means no earlier row failed this sweep.
               if (err_mask_q == '0) err_y_d = y_in;
            end
            if (r_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               r_d      = r_q + 2'd1;
               cnt_load = 1'b1;
               state_d  = S_DRIVE;
            end
         end
         S_DONE: begin
            if (loop_en || start) sweep_init = 1'b1;
            else                  state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (sweep_init) begin
         state_d    = S_DRIVE;
         r_d        = '0;
         err_mask_d = '0;
         err_y_d    = '0;
         cnt_load   = 1'b1;
      end
   end

   // Output stage registers the decode of the current state, so status outputs
   // trail the FSM by one cycle (done/pass appear 4*(DWELL_CYCLES+1)+1 edges
   // after the start edge, and busy drops exactly in the done cycle).
   always_comb begin
      a_d    = r_q[1];
      b_d    = r_q[0];
      busy_d = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
      done_d = (state_q == S_DONE);
      pass_d = (state_q == S_DONE) ? (err_mask_q == '0) : pass_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         r_q        <= '0;
         err_mask_q <= '0;
         err_y_q    <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         err_mask_q <= err_mask_d;
         err_y_q    <= err_y_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_mask = err_mask_q;
   assign err_y    = err_y_q;

endmodule
